hbridge_multi_controller: RTL and testbench
===========================================

// Module: hbridge_multi_controller
// PURPOSE
//  N_CH-channel successor to the single H-bridge gate controller. Each channel turns fwd/rev drive
//  requests into four gate enables (Q1..Q4): FWD = Q1&Q4, REV = Q3&Q2. Every channel enforces a
//  programmable dead time and blocks a direction reversal until the coil's flyback interval expires.
//  Sits between the PWM generators and the gate-driver pins; one instance drives all coils.
// PARAMETERS
//  N_CH        4   number of independent bridge channels
//  CNT_W       10  width of the on/flyback counters; both saturate at 2**CNT_W-1
//  DEAD_CYC    2   all-off cycles inserted before any drive begins; 0 is legal (no dead time)
//  FLY_MARGIN  4   extra flyback cycles added to the measured on-time; sum saturates
// PORTS
//  clk       in   1     system clock, 12 MHz
//  rst       in   1     synchronous, active-high reset
//  en        in   N_CH  channel enable; when low, the channel is forced to IDLE
//  in_fwd    in   N_CH  forward drive request (already synchronous to clk)
//  in_rev    in   N_CH  reverse drive request
//  fault_clr in   1     clears latched faults (HB_FAULT_LATCH_EN only)
//  q1..q4    out  N_CH  gate enables, registered
//  busy      out  N_CH  channel is not IDLE, or fly_cnt != 0
//  fault     out  N_CH  sticky fault flag; tied to 0 without the macro
// BEHAVIOUR
//  Reset: every output is 0. state=IDLE, on_cnt=fly_cnt=dead_cnt=0, last_dir=FWD.
//  Per-channel FSM, updated on the clk edge: IDLE -> DEAD -> DRIVE -> IDLE.
//  - A request is valid when en=1, exactly one of in_fwd/in_rev is 1, and either
//    dir==last_dir or fly_cnt==0.
//  - IDLE: all Q low; fly_cnt counts down by 1 per cycle until it reaches 0.
//    On a valid request: go to DEAD, latch dir, load dead_cnt=DEAD_CYC.
//      If dir==last_dir: preload on_cnt=fly_cnt (residual coil current), then clear fly_cnt.
//      Otherwise: on_cnt=0.
//    An opposite-direction request while fly_cnt!=0 is held off; no state change.
//  - DEAD: all Q low; dead_cnt decrements. Go to DRIVE when dead_cnt==0.
//    When DEAD_CYC=0, DEAD lasts 0 cycles and the channel passes straight through.
//  - DEAD abort: the request drops, or en=0, or both requests are high.
//    Go to IDLE and restore fly_cnt=on_cnt.
//  - DRIVE: assert Q1,Q4 (FWD) or Q3,Q2 (REV); on_cnt increments, saturating.
//    Exit to IDLE when the request drops, or the opposite request or both requests are
//    seen, or en=0. On exit: fly_cnt=sat(on_cnt+FLY_MARGIN), last_dir=dir, all Q low.
//  Latency
//    - Q rises DEAD_CYC+1 edges after the first edge that samples a valid request.
//    - Q falls 1 edge after the request is sampled low.
//    - Consequence: a request held for exactly k cycles gives k-DEAD_CYC drive cycles.
//  Invariants
//    - Q1&Q2 and Q3&Q4 are never both 1.
//    - FWD and REV are never both set, in any cycle.
//  Boundaries
//    - Counters saturate and never wrap.
//    - rst during DRIVE forces all Q low on that same edge.
//    - Channels are fully independent; en affects only its own channel.
// CONFIGURATION
//  HB_FAULT_LATCH_EN defined:
//    - fault[ch] sets on either of:
//        (a) in_fwd&in_rev sampled high, or
//        (b) an opposite request arriving while fly_cnt!=0.
//    - While fault=1 the channel is held in IDLE; fly_cnt still counts down.
//    - fault clears on fault_clr=1 when both requests of that channel are low.
//  HB_FAULT_LATCH_EN undefined:
//    - The fault port is constant 0 and fault_clr is ignored.
//    - Conditions (a) and (b) only block or abort the drive, exactly as in BEHAVIOUR.
// STRUCTURE
//  Package hbridge_pkg:
//    - hb_state_t enum {IDLE, DEAD, DRIVE}.
//    - hb_dir_t enum {DIR_FWD, DIR_REV}.
//    - sat_add / sat_inc helper functions.
//  Sub-module hbridge_channel:
//    - Owns one channel's FSM and counters.
//    - The top level is a generate loop over N_CH plus the shared fault_clr fan-out.
// TESTING  (N_CH=4, CNT_W=10, DEAD_CYC=2, FLY_MARGIN=4 unless stated)
//  1. ch0 in_fwd=1 for 10 cycles, then 0
//     -> q1&q4 high for 8 cycles starting at edge 3; fly_cnt=12; busy low 12 cycles after release.
//  2. Scenario 1, then in_rev=1 held from 5 cycles after release
//     -> no REV until fly_cnt=0; q3&q2 rise 3 edges later; with macro, fault[0]=1 and no drive.
//  3. in_fwd=in_rev=1 in IDLE; also both high mid-DRIVE
//     -> all Q stay or go low next edge; without macro fault=0, with macro fault=1
//        until fault_clr with both requests low.
//  4. CNT_W=4, in_rev held 40 cycles
//     -> on_cnt sticks at 15; fly_cnt=15 (saturated, no wrap).
//  5. rst=1 asserted mid-DRIVE on ch1 while ch2 drives FWD
//     -> every Q, busy and counter is 0 at that edge; FSM in IDLE.
//  6. 1-on/1-off fwd PWM on ch3 with DEAD_CYC=0 plus en[3] toggling
//     -> q1&q4 follow the input delayed 1 edge; en=0 drops Q next edge; ch0-2 unaffected.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared types and saturating arithmetic helpers for the multi-channel H-bridge controller.
package hbridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } hb_state_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } hb_dir_t;

  // Counters are carried through these helpers at 32 bits; callers cast back to their width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] a, input logic [31:0] max_val);
    if (a >= max_val) return max_val;
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: dead-time insertion, flyback hold-off and registered gate enables.
// Optional fault latching is compiled in with HB_FAULT_LATCH_EN.
//
//  state | meaning
//  IDLE  | all gates off; fly_cnt bleeds down toward 0
//  DEAD  | all gates off; dead_cnt counts the break-before-make gap
//  DRIVE | one diagonal pair on; on_cnt measures coil charge time
//
// Gate enables are registered from the current state, so they trail the state by one edge.
// DEAD is left one edge early to compensate, giving Q rise DEAD_CYC+1 edges after acceptance.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int DEAD_CYC   = 2,
  parameter int FLY_MARGIN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_fwd,
  input  logic in_rev,
  input  logic fault_clr,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic q4,
  output logic busy,
  output logic fault
);

  localparam int          DEAD_W  = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  hb_state_t        state, state_nxt;
  hb_dir_t          dir, dir_nxt, last_dir, last_dir_nxt, req_dir;
  logic [CNT_W-1:0] on_cnt, on_nxt, fly_cnt, fly_nxt, on_inc, fly_exit;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;
  logic             both, one_req, hold, valid;
  logic             q_fwd, q_rev;

  // Request qualification and next-state/counter computation.
  always_comb begin
    both         = in_fwd & in_rev;
    one_req      = en & (in_fwd ^ in_rev);
    req_dir      = in_rev ? DIR_REV : DIR_FWD;
    hold         = one_req && (req_dir == dir);
    valid        = one_req && ((req_dir == last_dir) || (fly_cnt == '0)) && !fault;
    on_inc       = CNT_W'(sat_inc(32'(on_cnt), CNT_MAX));
    fly_exit     = CNT_W'(sat_add(32'(on_inc), 32'(FLY_MARGIN), CNT_MAX));
    state_nxt    = state;
    dir_nxt      = dir;
    last_dir_nxt = last_dir;
    on_nxt       = on_cnt;
    fly_nxt      = fly_cnt;
    dead_nxt     = dead_cnt;
    case (state)
      IDLE: begin
        if (fly_cnt != '0) fly_nxt = fly_cnt - CNT_W'(1);
        if (valid) begin
          dir_nxt  = req_dir;
          dead_nxt = DEAD_W'(DEAD_CYC);
          if (DEAD_CYC == 0) state_nxt = DRIVE;
          else               state_nxt = DEAD;
          // Same direction: residual coil current counts as already-accumulated on-time.
          if (req_dir == last_dir) begin
            on_nxt  = fly_cnt;
            fly_nxt = '0;
          end else begin
            on_nxt = '0;
          end
        end
      end
      DEAD: begin
        if (!hold) begin
          state_nxt = IDLE;
          fly_nxt   = on_cnt;
        end else if (dead_cnt <= DEAD_W'(1)) begin
          state_nxt = DRIVE;
          dead_nxt  = '0;
        end else begin
          dead_nxt = dead_cnt - DEAD_W'(1);
        end
      end
      DRIVE: begin
        on_nxt = on_inc;
        if (!hold) begin
          state_nxt    = IDLE;
          fly_nxt      = fly_exit;
          last_dir_nxt = dir;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered gate enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir      <= DIR_FWD;
      last_dir <= DIR_FWD;
      on_cnt   <= '0;
      fly_cnt  <= '0;
      dead_cnt <= '0;
      q_fwd    <= 1'b0;
      q_rev    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      last_dir <= last_dir_nxt;
      on_cnt   <= on_nxt;
      fly_cnt  <= fly_nxt;
      dead_cnt <= dead_nxt;
      q_fwd    <= (state == DRIVE) && (dir == DIR_FWD);
      q_rev    <= (state == DRIVE) && (dir == DIR_REV);
    end
  end

  assign q1   = q_fwd;
  assign q4   = q_fwd;
  assign q3   = q_rev;
  assign q2   = q_rev;
  assign busy = (state != IDLE) || (fly_cnt != '0);

`ifdef HB_FAULT_LATCH_EN
  logic fault_q, fault_set;

  // Conflicting requests or a reversal attempt during flyback latch a fault.
  always_comb begin
    fault_set = both ||
                ((state == IDLE) && one_req && (req_dir != last_dir) && (fly_cnt != '0));
  end

  // Sticky fault flag; clearing is only honoured once both requests have been released.
  always_ff @(posedge clk) begin
    if (rst)                                   fault_q <= 1'b0;
    else if (fault_set)                        fault_q <= 1'b1;
    else if (fault_clr && !in_fwd && !in_rev)  fault_q <= 1'b0;
  end

  assign fault = fault_q;
`else
  logic unused_fault_clr;
  logic unused_both;
  assign unused_fault_clr = fault_clr;
  assign unused_both      = both;
  assign fault            = 1'b0;
`endif

endmodule

// File: rtl/hbridge_multi_controller.sv
// N_CH independent H-bridge channels sharing clock, reset and the fault-clear strobe.
// Optional fault latching is compiled in with HB_FAULT_LATCH_EN.
module hbridge_multi_controller
  import hbridge_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 10,
  parameter int DEAD_CYC   = 2,
  parameter int FLY_MARGIN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] in_fwd,
  input  logic [N_CH-1:0] in_rev,
  input  logic            fault_clr,
  output logic [N_CH-1:0] q1,
  output logic [N_CH-1:0] q2,
  output logic [N_CH-1:0] q3,
  output logic [N_CH-1:0] q4,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] fault
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    hbridge_channel #(
      .CNT_W      (CNT_W),
      .DEAD_CYC   (DEAD_CYC),
      .FLY_MARGIN (FLY_MARGIN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[ch]),
      .in_fwd    (in_fwd[ch]),
      .in_rev    (in_rev[ch]),
      .fault_clr (fault_clr),
      .q1        (q1[ch]),
      .q2        (q2[ch]),
      .q3        (q3[ch]),
      .q4        (q4[ch]),
      .busy      (busy[ch]),
      .fault     (fault[ch])
    );
  end

endmodule

// File: tb/tb_hbridge_multi_controller.sv
// Directed bench: default build plus a narrow-counter and a zero-dead-time instance on shared inputs.
module tb_hbridge_multi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en, in_fwd, in_rev;
  logic       fault_clr;

  logic [3:0] q1, q2, q3, q4, busy, fault;
  logic [3:0] w_q1, w_q2, w_q3, w_q4, w_busy, w_fault;
  logic [3:0] d_q1, d_q2, d_q3, d_q4, d_busy, d_fault;

  int checks   = 0;
  int failures = 0;

  hbridge_multi_controller #(.N_CH(4), .CNT_W(10), .DEAD_CYC(2), .FLY_MARGIN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_fwd(in_fwd), .in_rev(in_rev), .fault_clr(fault_clr),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .busy(busy), .fault(fault));

  hbridge_multi_controller #(.N_CH(4), .CNT_W(4), .DEAD_CYC(2), .FLY_MARGIN(4)) dut_w4 (
    .clk(clk), .rst(rst), .en(en), .in_fwd(in_fwd), .in_rev(in_rev), .fault_clr(fault_clr),
    .q1(w_q1), .q2(w_q2), .q3(w_q3), .q4(w_q4), .busy(w_busy), .fault(w_fault));

  hbridge_multi_controller #(.N_CH(4), .CNT_W(10), .DEAD_CYC(0), .FLY_MARGIN(4)) dut_d0 (
    .clk(clk), .rst(rst), .en(en), .in_fwd(in_fwd), .in_rev(in_rev), .fault_clr(fault_clr),
    .q1(d_q1), .q2(d_q2), .q3(d_q3), .q4(d_q4), .busy(d_busy), .fault(d_fault));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 4'hF; in_fwd = 4'h0; in_rev = 4'h0; fault_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 4'hF; in_fwd = 4'h0; in_rev = 4'h0; fault_clr = 1'b0;
    tick;
    checks++;
    if ({q1, q2, q3, q4, busy, fault} !== 24'h0) begin
      failures++; $display("FAIL reset_main got=%h exp=0", {q1, q2, q3, q4, busy, fault});
    end
    checks++;
    if ({w_q1, w_q2, w_q3, w_q4, w_busy, w_fault} !== 24'h0) begin
      failures++; $display("FAIL reset_w4 got=%h exp=0", {w_q1, w_q2, w_q3, w_q4, w_busy, w_fault});
    end
    checks++;
    if ({d_q1, d_q2, d_q3, d_q4, d_busy, d_fault} !== 24'h0) begin
      failures++; $display("FAIL reset_d0 got=%h exp=0", {d_q1, d_q2, d_q3, d_q4, d_busy, d_fault});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({q1, q2, q3, q4, busy, fault} !== 24'h0) begin
        failures++; $display("FAIL idle_quiet cyc=%0d got=%h exp=0", i, {q1, q2, q3, q4, busy, fault});
      end
    end
  endtask

  task automatic test_fwd_pulse;
    logic exp_f, exp_b;
    do_reset;
    in_fwd[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick;
      exp_f = (i >= 3) && (i <= 10);
      exp_b = (i < 22);
      checks++;
      if ({q1[0], q4[0]} !== {exp_f, exp_f}) begin
        failures++; $display("FAIL fwd_pulse_q14 edge=%0d got=%b%b exp=%b", i, q1[0], q4[0], exp_f);
      end
      checks++;
      if ({q2[0], q3[0]} !== 2'b00) begin
        failures++; $display("FAIL fwd_pulse_q23 edge=%0d got=%b%b exp=00", i, q2[0], q3[0]);
      end
      checks++;
      if (busy[0] !== exp_b) begin
        failures++; $display("FAIL fwd_pulse_busy edge=%0d got=%b exp=%b", i, busy[0], exp_b);
      end
      if (i == 9) in_fwd[0] = 1'b0;
    end
  endtask

  task automatic test_reversal;
    logic exp_f, exp_r, exp_b;
    do_reset;
    in_fwd[0] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick;
      exp_f = (i >= 3) && (i <= 10);
      exp_r = (i >= 26);
      exp_b = (i != 22);
      checks++;
      if ({q1[0], q4[0]} !== {exp_f, exp_f}) begin
        failures++; $display("FAIL rev_fwd_q14 edge=%0d got=%b%b exp=%b", i, q1[0], q4[0], exp_f);
      end
      checks++;
      if ({q3[0], q2[0]} !== {exp_r, exp_r}) begin
        failures++; $display("FAIL rev_q32 edge=%0d got=%b%b exp=%b", i, q3[0], q2[0], exp_r);
      end
      checks++;
      if (busy[0] !== exp_b) begin
        failures++; $display("FAIL rev_busy edge=%0d got=%b exp=%b", i, busy[0], exp_b);
      end
      checks++;
      if (fault[0] !== 1'b0) begin
        failures++; $display("FAIL rev_fault edge=%0d got=%b exp=0", i, fault[0]);
      end
      if (i == 9)  in_fwd[0] = 1'b0;
      if (i == 14) in_rev[0] = 1'b1;
    end
    in_rev[0] = 1'b0;
  endtask

  task automatic test_both_requests;
    logic exp_f;
    do_reset;
    in_fwd[1] = 1'b1;
    in_rev[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if ({q1[1], q2[1], q3[1], q4[1], busy[1], fault[1]} !== 6'b0) begin
        failures++;
        $display("FAIL both_idle cyc=%0d got=%b exp=000000", i, {q1[1], q2[1], q3[1], q4[1], busy[1], fault[1]});
      end
    end
    in_rev[1] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick;
      exp_f = (i >= 3) && (i <= 5);
      checks++;
      if ({q1[1], q4[1]} !== {exp_f, exp_f}) begin
        failures++; $display("FAIL both_drive_q14 edge=%0d got=%b%b exp=%b", i, q1[1], q4[1], exp_f);
      end
      checks++;
      if ({q2[1], q3[1], fault[1]} !== 3'b000) begin
        failures++; $display("FAIL both_drive_q23f edge=%0d got=%b exp=000", i, {q2[1], q3[1], fault[1]});
      end
      if (i == 4) in_rev[1] = 1'b1;
    end
    in_fwd[1] = 1'b0;
    in_rev[1] = 1'b0;
  endtask

  task automatic test_saturation;
    logic exp_r, exp_b;
    do_reset;
    in_rev[0] = 1'b1;
    for (int i = 0; i < 57; i++) begin
      tick;
      exp_r = (i >= 3) && (i <= 40);
      exp_b = (i < 55);
      checks++;
      if ({w_q3[0], w_q2[0]} !== {exp_r, exp_r}) begin
        failures++; $display("FAIL sat_q32 edge=%0d got=%b%b exp=%b", i, w_q3[0], w_q2[0], exp_r);
      end
      checks++;
      if (w_busy[0] !== exp_b) begin
        failures++; $display("FAIL sat_busy edge=%0d got=%b exp=%b", i, w_busy[0], exp_b);
      end
      if (i == 39) in_rev[0] = 1'b0;
    end
  endtask

  task automatic test_rst_mid_drive;
    logic exp_q;
    do_reset;
    in_rev[1] = 1'b1;
    in_fwd[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      exp_q = (i >= 3);
      checks++;
      if ({q3[1], q2[1], q1[2], q4[2]} !== {4{exp_q}}) begin
        failures++; $display("FAIL pre_rst_drive edge=%0d got=%b exp=%b", i, {q3[1], q2[1], q1[2], q4[2]}, exp_q);
      end
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({q1, q2, q3, q4, busy, fault} !== 24'h0) begin
      failures++; $display("FAIL rst_drive_main got=%h exp=0", {q1, q2, q3, q4, busy, fault});
    end
    checks++;
    if ({w_q1, w_q2, w_q3, w_q4, w_busy, w_fault} !== 24'h0) begin
      failures++; $display("FAIL rst_drive_w4 got=%h exp=0", {w_q1, w_q2, w_q3, w_q4, w_busy, w_fault});
    end
    checks++;
    if ({d_q1, d_q2, d_q3, d_q4, d_busy, d_fault} !== 24'h0) begin
      failures++; $display("FAIL rst_drive_d0 got=%h exp=0", {d_q1, d_q2, d_q3, d_q4, d_busy, d_fault});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      exp_q = (i >= 3);
      checks++;
      if ({q3[1], q2[1], q1[2], q4[2]} !== {4{exp_q}}) begin
        failures++; $display("FAIL post_rst_drive edge=%0d got=%b exp=%b", i, {q3[1], q2[1], q1[2], q4[2]}, exp_q);
      end
    end
    in_rev[1] = 1'b0;
    in_fwd[2] = 1'b0;
  endtask

  task automatic test_pwm_en;
    logic [15:0] pwm_pat;
    logic [15:0] en_pat;
    logic        prev, exp3, exp0;
    pwm_pat = 16'b0011_0101_0111_0101;
    en_pat  = 16'b1111_1011_0011_1111;
    prev    = 1'b0;
    do_reset;
    in_fwd[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_fwd[3] = pwm_pat[i];
      en[3]     = en_pat[i];
      tick;
      exp3 = prev;
      prev = pwm_pat[i] & en_pat[i];
      exp0 = (i >= 1);
      checks++;
      if ({d_q1[3], d_q4[3]} !== {exp3, exp3}) begin
        failures++; $display("FAIL pwm_ch3_q14 step=%0d got=%b%b exp=%b", i, d_q1[3], d_q4[3], exp3);
      end
      checks++;
      if ({d_q2[3], d_q3[3]} !== 2'b00) begin
        failures++; $display("FAIL pwm_ch3_q23 step=%0d got=%b%b exp=00", i, d_q2[3], d_q3[3]);
      end
      checks++;
      if ({d_q1[0], d_q4[0]} !== {exp0, exp0}) begin
        failures++; $display("FAIL pwm_ch0_indep step=%0d got=%b%b exp=%b", i, d_q1[0], d_q4[0], exp0);
      end
      checks++;
      if ({d_q1[2:1], d_q2[2:1], d_q3[2:1], d_q4[2:1]} !== 8'h00) begin
        failures++;
        $display("FAIL pwm_ch12_quiet step=%0d got=%h exp=0", i, {d_q1[2:1], d_q2[2:1], d_q3[2:1], d_q4[2:1]});
      end
    end
    in_fwd = 4'h0;
    en     = 4'hF;
  endtask

  initial begin
    rst = 1'b1; en = 4'hF; in_fwd = 4'h0; in_rev = 4'h0; fault_clr = 1'b0;
    test_reset;
    test_fwd_pulse;
    test_reversal;
    test_both_requests;
    test_saturation;
    test_rst_mid_drive;
    test_pwm_en;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
